// File: rtl/formula_pipe_stream_adapter.sv
// Valid/ready stream adapter in front of a fixed-latency, valid-only formula pipe.
// Each argument set is admitted only against a credit, so the result FIFO always has room for its result.
module formula_pipe_stream_adapter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_c,
  output logic             pipe_arg_vld,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic [WIDTH-1:0] pipe_c,
  input  logic             pipe_res_vld,
  input  logic [WIDTH-1:0] pipe_res,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [WIDTH-1:0] down_data,
  output logic             err_stray
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [CW-1:0]    credits, credits_nxt;
  logic [CW-1:0]    inflight, inflight_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic issue, pop, push, full, res_expected, stray;

  // up_rdy depends only on the credit register (and reset), never on up_vld
  assign up_rdy       = ~rst & (credits != '0);
  assign issue        = up_vld & up_rdy;
  assign full         = (count == DEPTH_C);
  assign down_vld     = (count != '0);
  assign pop          = down_vld & down_rdy;
  assign res_expected = (inflight != '0);
  assign push         = pipe_res_vld & res_expected & ~full;
  assign stray        = pipe_res_vld & (~res_expected | full);
  assign down_data    = down_vld ? mem[rd_ptr] : '0;

  always_comb begin
    credits_nxt  = credits;
    inflight_nxt = inflight;
    count_nxt    = count;
    if (issue && !pop)      credits_nxt = credits - ONE_C;
    else if (pop && !issue) credits_nxt = credits + ONE_C;
    if (issue && !(pipe_res_vld && res_expected))      inflight_nxt = inflight + ONE_C;
    else if (!issue && pipe_res_vld && res_expected)   inflight_nxt = inflight - ONE_C;
    if (push && !pop)      count_nxt = count + ONE_C;
    else if (pop && !push) count_nxt = count - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= DEPTH_C;
      inflight     <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_stray    <= 1'b0;
      pipe_arg_vld <= 1'b0;
      pipe_a       <= '0;
      pipe_b       <= '0;
      pipe_c       <= '0;
    end else begin
      credits      <= credits_nxt;
      inflight     <= inflight_nxt;
      count        <= count_nxt;
      pipe_arg_vld <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (stray) err_stray <= 1'b1;
      // operands hold when idle so the pipe sees no toggling
      if (issue) begin
        pipe_a <= up_a;
        pipe_b <= up_b;
        pipe_c <= up_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pipe_res;
  end

endmodule

// File: tb/tb_formula_pipe_stream_adapter.sv
// Bench for formula_pipe_stream_adapter with a behavioural sqrt(a)+sqrt(b)+sqrt(c) pipe of latency L.
// Expected results are queued at each upstream handshake and checked by a monitor at each pop.
module tb_formula_pipe_stream_adapter;
  localparam int W = 32;
  localparam int DEPTH = 8;
  localparam int L = 5;

  logic clk, rst;
  logic up_vld, up_rdy;
  logic [W-1:0] up_a, up_b, up_c;
  logic pipe_arg_vld;
  logic [W-1:0] pipe_a, pipe_b, pipe_c;
  logic pipe_res_vld;
  logic [W-1:0] pipe_res;
  logic down_vld, down_rdy;
  logic [W-1:0] down_data;
  logic err_stray;
  logic stray_inj;

  int vecs = 0;
  int errs = 0;
  int hs_cnt = 0;
  logic [W-1:0] sb[$];
  logic held;
  logic [W-1:0] held_data;

  formula_pipe_stream_adapter #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_a(up_a), .up_b(up_b), .up_c(up_c),
    .pipe_arg_vld(pipe_arg_vld), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
    .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .down_vld(down_vld), .down_rdy(down_rdy), .down_data(down_data),
    .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int i = 15; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= 64'(x)) r = t;
    end
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
    return isqrt(a) + isqrt(b) + isqrt(c);
  endfunction

  // formula pipe stand-in: L register stages, valid-only
  logic [L-1:0] pv;
  logic [W-1:0] pr [L];
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else pv <= {pv[L-2:0], pipe_arg_vld};
    pr[0] <= ref_f(pipe_a, pipe_b, pipe_c);
    for (int i = 1; i < L; i++) pr[i] <= pr[i-1];
  end
  assign pipe_res_vld = pv[L-1] | stray_inj;
  assign pipe_res     = pr[L-1];

  task automatic check(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      held <= 1'b0;
    end else begin
      if (held && down_vld) check("stall_stable", down_data, held_data);
      held      <= down_vld & ~down_rdy;
      held_data <= down_data;
      if (down_vld && down_rdy) begin
        if (sb.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_result: got %0d, required no result", down_data);
        end else begin
          check("result", down_data, sb.pop_front());
        end
      end
      if (up_vld && up_rdy) begin
        sb.push_back(ref_f(up_a, up_b, up_c));
        hs_cnt <= hs_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    down_rdy = 1'b1;
    up_vld = 1'b0;
    while ((sb.size() != 0 || down_vld) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < 300), 1);
    step();
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      up_vld = 1'b1;
      up_a = $urandom_range(0, 65535);
      up_b = $urandom_range(0, 65535);
      up_c = $urandom_range(0, 65535);
    end
    step();
    up_vld = 1'b0;
  endtask

  initial begin
    int k, bad, hs0;
    rst = 1'b1; up_vld = 1'b0; up_a = '0; up_b = '0; up_c = '0;
    down_rdy = 1'b0; stray_inj = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_up_rdy", up_rdy, 0);
    check("rst_down_vld", down_vld, 0);
    check("rst_down_data", down_data, 0);
    check("rst_pipe_arg_vld", pipe_arg_vld, 0);
    check("rst_err_stray", err_stray, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_up_rdy", up_rdy, 1);

    // single set and latency
    step();
    up_vld = 1'b1; up_a = 4; up_b = 9; up_c = 16; down_rdy = 1'b1;
    @(negedge clk);
    check("single_handshake", up_rdy, 1);
    step();
    up_vld = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!down_vld && k < 30);
    check("single_latency", k, L + 2);
    check("single_data", down_data, 9);
    step();
    @(negedge clk);
    check("single_pulse", down_vld, 0);
    check("single_err", err_stray, 0);

    // back-to-back stream
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      up_vld = 1'b1; up_a = i * i; up_b = i * i; up_c = i * i;
      @(negedge clk);
      if (!up_rdy) bad++;
    end
    step();
    up_vld = 1'b0;
    check("stream_up_rdy_drops", bad, 0);
    drain();

    // stall: exactly DEPTH handshakes
    down_rdy = 1'b0;
    hs0 = hs_cnt;
    issue_n(20);
    @(negedge clk);
    check("stall_handshakes", hs_cnt - hs0, DEPTH);
    check("stall_up_rdy", up_rdy, 0);
    repeat (L + 3) step();
    @(negedge clk);
    check("stall_down_vld", down_vld, 1);
    check("stall_err", err_stray, 0);
    step();
    down_rdy = 1'b1;
    @(negedge clk);
    check("first_pop_up_rdy", up_rdy, 0);
    @(negedge clk);
    check("after_pop_up_rdy", up_rdy, 1);
    drain();

    // simultaneous pop and issue on the last credit
    down_rdy = 1'b0;
    issue_n(DEPTH - 1);
    repeat (L + 3) step();
    @(negedge clk);
    check("one_credit_left", up_rdy, 1);
    step();
    up_vld = 1'b1; down_rdy = 1'b1;
    up_a = 25; up_b = 36; up_c = 49;
    @(negedge clk);
    check("pop_issue_hs", up_rdy & down_vld, 1);
    step();
    up_vld = 1'b0; down_rdy = 1'b0;
    @(negedge clk);
    check("pop_issue_credit_kept", up_rdy, 1);
    step();
    up_vld = 1'b1;
    step();
    up_vld = 1'b0;
    @(negedge clk);
    check("last_credit_used", up_rdy, 0);
    drain();

    // operand hold while idle
    step();
    up_vld = 1'b1; up_a = 1; up_b = 1; up_c = 1; down_rdy = 1'b1;
    step();
    up_vld = 1'b0; up_a = $urandom; up_b = $urandom; up_c = $urandom;
    @(negedge clk);
    check("power_arg_vld_pulse", pipe_arg_vld, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      up_a = $urandom; up_b = $urandom; up_c = $urandom;
      @(negedge clk);
      if (pipe_arg_vld || pipe_a != 1 || pipe_b != 1 || pipe_c != 1) bad++;
    end
    check("power_hold", bad, 0);
    drain();

    // random traffic with random consumer stalls
    for (int i = 0; i < 200; i++) begin
      step();
      up_vld = 1'($urandom_range(0, 1));
      up_a = $urandom_range(0, 65535);
      up_b = $urandom_range(0, 65535);
      up_c = $urandom_range(0, 65535);
      down_rdy = ($urandom_range(0, 3) != 0);
    end
    drain();
    check("random_err", err_stray, 0);

    // reset with results in the FIFO and in flight
    down_rdy = 1'b0;
    issue_n(3);
    repeat (L + 3) step();
    for (int i = 0; i < 5; i++) begin
      up_vld = 1'b1;
      up_a = $urandom_range(0, 65535);
      step();
    end
    up_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_up_rdy", up_rdy, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_down_vld", down_vld, 0);
    check("midrst_up_rdy_back", up_rdy, 1);
    hs0 = hs_cnt;
    issue_n(12);
    @(negedge clk);
    check("midrst_full_credits", hs_cnt - hs0, DEPTH);
    drain();
    step();
    stray_inj = 1'b1;
    step();
    stray_inj = 1'b0;
    @(negedge clk);
    check("stray_err", err_stray, 1);
    check("stray_no_result", down_vld, 0);
    repeat (5) step();
    @(negedge clk);
    check("stray_sticky", err_stray, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
